// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous SRAM port between the fetch stage
// (read-only) and the memory stage (read/write). One transaction is in flight
// at a time. The response cycle of one transaction may issue the next one, so
// requests can run back-to-back. Data wins arbitration unless fetch has been
// starved for STARVE_MAX data grants in a row. A cancel from writeback drops
// the pending response and blocks grants for that cycle.
module mem_port_arbiter #(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cancel,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] LAT_CNT  = 3'(LATENCY);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       drop_q, drop_d;
  logic [3:0] starve_q, starve_d;

  logic resp_cycle;
  logic can_issue;
  logic inst_starved;
  logic grant_data;
  logic grant_inst;
  logic resp_ok;

  // Arbitration: issue only when the port is free (idle or response cycle),
  // data first unless fetch has hit its starvation limit.
  always_comb begin
    resp_cycle   = (state_q == S_WAIT) && (cnt_q == 3'd1);
    can_issue    = (state_q == S_IDLE) || resp_cycle;
    inst_starved = inst_req && (starve_q == STARVE_LIM);
    grant_data   = can_issue && !cancel && resetn && data_req && !inst_starved;
    grant_inst   = can_issue && !cancel && resetn && !grant_data && inst_req;
    resp_ok      = resp_cycle && !drop_q && !cancel && resetn;
  end

  // Requester handshakes, SRAM drive and response strobes; everything is held
  // at zero while reset is asserted.
  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    mem_en       = grant_inst || grant_data;
    mem_addr     = 32'd0;
    if (grant_data) begin
      mem_addr = data_addr;
    end else if (grant_inst) begin
      mem_addr = inst_addr;
    end
    mem_wen      = (grant_data && data_wr) ? data_wstrb : 4'd0;
    mem_wdata    = mem_en ? data_wdata : 32'd0;
    inst_data_ok = resp_ok && !owner_q;
    data_data_ok = resp_ok && owner_q;
    inst_rdata   = resetn ? mem_rdata : 32'd0;
    data_rdata   = resetn ? mem_rdata : 32'd0;
    busy         = resetn && (state_q == S_WAIT);
  end

  // Next-state logic: a grant (re)arms the latency counter, otherwise WAIT
  // counts down and remembers any cancel seen before the response cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    drop_d   = drop_q;
    starve_d = starve_q;
    if (grant_inst || grant_data) begin
      state_d = S_WAIT;
      cnt_d   = LAT_CNT;
      owner_d = grant_data;
      drop_d  = 1'b0;
    end else if (state_q == S_WAIT) begin
      if (cnt_q == 3'd1) begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        drop_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - 3'd1;
        if (cancel) begin
          drop_d = 1'b1;
        end
      end
    end
    if (grant_inst || !inst_req) begin
      starve_d = 4'd0;
    end else if (grant_data && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      owner_q  <= 1'b0;
      drop_q   <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (LATENCY 1 / STARVE_MAX 4 and
// LATENCY 3 / STARVE_MAX 2), each with its own requesters and SRAM model.
// A reference model predicts grants and queues expected responses; a monitor
// pops them when their due cycle arrives and compares against the DUT.
module tb_mem_port_arbiter;

  localparam int LAT0  = 1;
  localparam int LAT1  = 3;
  localparam int SMAX0 = 4;
  localparam int SMAX1 = 2;

  logic        clk;
  logic        resetn;
  logic        cancel       [2];
  logic        inst_req     [2];
  logic [31:0] inst_addr    [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic [31:0] inst_rdata   [2];
  logic        data_req     [2];
  logic        data_wr      [2];
  logic [3:0]  data_wstrb   [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic [31:0] data_rdata   [2];
  logic        mem_en       [2];
  logic [3:0]  mem_wen      [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic [31:0] mem_rdata    [2];
  logic        busy         [2];

  int n_checks;
  int n_fail;
  int cyc;

  typedef struct {
    int          k;
    logic        owner;
    logic        wr;
    logic        drop;
    logic [31:0] rdata;
    int          due;
  } resp_t;

  resp_t sb[$];

  logic [31:0] sram    [2][16];
  logic [31:0] rd_pipe [2][4];
  logic        sram_ready;
  logic [31:0] img     [2][16];
  logic        img_ready;
  logic        m_pend   [2];
  int          m_due    [2];
  int          m_starve [2];

  logic acc_i [2];
  logic acc_d [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .LATENCY   ((g == 0) ? LAT0 : LAT1),
      .STARVE_MAX((g == 0) ? SMAX0 : SMAX1)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .cancel      (cancel[g]),
      .inst_req    (inst_req[g]),
      .inst_addr   (inst_addr[g]),
      .inst_addr_ok(inst_addr_ok[g]),
      .inst_data_ok(inst_data_ok[g]),
      .inst_rdata  (inst_rdata[g]),
      .data_req    (data_req[g]),
      .data_wr     (data_wr[g]),
      .data_wstrb  (data_wstrb[g]),
      .data_addr   (data_addr[g]),
      .data_wdata  (data_wdata[g]),
      .data_addr_ok(data_addr_ok[g]),
      .data_data_ok(data_data_ok[g]),
      .data_rdata  (data_rdata[g]),
      .mem_en      (mem_en[g]),
      .mem_wen     (mem_wen[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g]),
      .busy        (busy[g])
    );
  end

  assign mem_rdata[0] = rd_pipe[0][LAT0-1];
  assign mem_rdata[1] = rd_pipe[1][LAT1-1];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int smax_of(input int k);
    return (k == 0) ? SMAX0 : SMAX1;
  endfunction

  function automatic logic [31:0] init_word(input int k, input int i);
    return 32'hC0DE_0000 + 32'(k) * 32'h100 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic checkOutput(input string name, input int k,
                             input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] cycle %0d actual=%h required=%h", name, k, cyc, act, req);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter used to time expected responses.
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: LATENCY-deep read pipeline, garbage when not enabled.
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++) sram[k][i] <= init_word(k, i);
      sram_ready <= 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      for (int j = 1; j < 4; j++) rd_pipe[k][j] <= rd_pipe[k][j-1];
      if (sram_ready && mem_en[k]) begin
        rd_pipe[k][0] <= sram[k][mem_addr[k][5:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wen[k][b]) sram[k][mem_addr[k][5:2]][b*8 +: 8] <= mem_wdata[k][b*8 +: 8];
      end else begin
        rd_pipe[k][0] <= $urandom;
      end
    end
  end

  // Reference model: decides who should be granted, checks the issue-side
  // outputs and queues the response each grant is owed.
  always @(negedge clk) begin
    logic        free, gd, gi, resp_now, req_wr;
    logic [31:0] addr;
    resp_t       e;
    if (!img_ready) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++) img[k][i] = init_word(k, i);
      img_ready = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_pend[k]   = 1'b0;
        m_starve[k] = 0;
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].k == k) sb.delete(i);
        checkOutput("reset_outputs", k,
          {22'd0, inst_addr_ok[k], data_addr_ok[k], mem_en[k], mem_wen[k], mem_addr[k],
           mem_wdata[k], busy[k], inst_data_ok[k], data_data_ok[k], inst_rdata[k], data_rdata[k]},
          160'd0);
      end else begin
        resp_now = m_pend[k] && (m_due[k] == cyc);
        free     = !m_pend[k] || resp_now;
        gd = free && !cancel[k] && data_req[k] && !(inst_req[k] && m_starve[k] == smax_of(k));
        gi = free && !cancel[k] && !gd && inst_req[k];
        req_wr = gd && data_wr[k];
        addr = gd ? data_addr[k] : (gi ? inst_addr[k] : 32'd0);
        checkOutput("issue", k,
          {88'd0, inst_addr_ok[k], data_addr_ok[k], mem_en[k], mem_wen[k], mem_addr[k],
           mem_wdata[k], busy[k]},
          {88'd0, gi, gd, gi || gd, req_wr ? data_wstrb[k] : 4'd0, addr,
           (gi || gd) ? data_wdata[k] : 32'd0, m_pend[k]});
        if (gi || !inst_req[k]) m_starve[k] = 0;
        else if (gd && m_starve[k] < smax_of(k)) m_starve[k]++;
        if (cancel[k] && m_pend[k]) begin
          for (int i = 0; i < sb.size(); i++)
            if (sb[i].k == k) begin
              e = sb[i];
              e.drop = 1'b1;
              sb[i] = e;
            end
        end
        if (resp_now) m_pend[k] = 1'b0;
        if (gi || gd) begin
          e.k     = k;
          e.owner = gd;
          e.wr    = req_wr;
          e.drop  = 1'b0;
          e.rdata = img[k][addr[5:2]];
          e.due   = cyc + lat_of(k);
          sb.push_back(e);
          m_pend[k] = 1'b1;
          m_due[k]  = cyc + lat_of(k);
          if (req_wr)
            for (int b = 0; b < 4; b++)
              if (data_wstrb[k][b]) img[k][addr[5:2]][b*8 +: 8] = data_wdata[k][b*8 +: 8];
        end
      end
    end
  end

  // Monitor: each cycle pops the response due now (if any) and compares the
  // data_ok strobes and read data the DUT presents.
  always @(negedge clk) begin
    int          idx;
    logic        exp_i, exp_d;
    resp_t       e;
    for (int k = 0; k < 2; k++) begin
      if (resetn) begin
        idx   = -1;
        exp_i = 1'b0;
        exp_d = 1'b0;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].k == k && sb[i].due == cyc) idx = i;
        if (idx >= 0) begin
          e = sb[idx];
          sb.delete(idx);
          if (!e.drop && !cancel[k]) begin
            exp_i = !e.owner;
            exp_d = e.owner;
          end
        end
        checkOutput("data_ok", k, {158'd0, inst_data_ok[k], data_data_ok[k]},
                    {158'd0, exp_i, exp_d});
        if (exp_i) checkOutput("inst_rdata", k, {128'd0, inst_rdata[k]}, {128'd0, e.rdata});
        if (exp_d && !e.wr) checkOutput("data_rdata", k, {128'd0, data_rdata[k]}, {128'd0, e.rdata});
      end
    end
  end

  // One cycle of requester behaviour: drop requests the DUT accepted, and
  // end any cancel pulse.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      acc_i[k] = inst_addr_ok[k];
      acc_d[k] = data_addr_ok[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (acc_i[k]) inst_req[k] = 1'b0;
      if (acc_d[k]) data_req[k] = 1'b0;
      cancel[k] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_accept();
    int c = 0;
    while ((inst_req[0] || inst_req[1] || data_req[0] || data_req[1]) && c < 30) begin
      step();
      c++;
    end
    checkOutput("accept_bound", 0, {159'd0, c < 30}, 160'd1);
  endtask

  // Random traffic on both instances with occasional cancel and reset.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        acc_i[k] = inst_addr_ok[k];
        acc_d[k] = data_addr_ok[k];
      end
      @(posedge clk);
      #1;
      resetn = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < 2; k++) begin
        cancel[k] = ($urandom_range(0, 11) == 0);
        if (!inst_req[k] || acc_i[k]) begin
          inst_req[k]  = ($urandom_range(0, 2) == 0);
          inst_addr[k] = 32'hBFC0_0000 + 32'($urandom_range(0, 15)) * 4;
        end
        if (!data_req[k] || acc_d[k]) begin
          data_req[k]   = ($urandom_range(0, 1) == 0);
          data_wr[k]    = ($urandom_range(0, 2) == 0);
          data_wstrb[k] = 4'($urandom);
          data_addr[k]  = 32'h0000_0100 + 32'($urandom_range(0, 15)) * 4;
          data_wdata[k] = $urandom;
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n3 [2];
    logic d3 [2];
    int n6 [2];
    int first6 [2];
    int last6 [2];
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    sram_ready = 1'b0;
    img_ready  = 1'b0;
    resetn     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cancel[k] = 1'b0; inst_req[k] = 1'b0; inst_addr[k] = 32'd0;
      data_req[k] = 1'b0; data_wr[k] = 1'b0; data_wstrb[k] = 4'd0;
      data_addr[k] = 32'd0; data_wdata[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Lone fetch from the reset vector.
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'hBFC0_0000;
    end
    wait_accept();
    idle(4);

    // Simultaneous fetch and data write, then read the written word back.
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'hBFC0_0004;
      data_req[k] = 1'b1; data_wr[k] = 1'b1; data_wstrb[k] = 4'hF;
      data_addr[k] = 32'h0000_0100; data_wdata[k] = 32'h1234_5678;
    end
    wait_accept();
    idle(4);
    for (int k = 0; k < 2; k++) begin
      data_req[k] = 1'b1; data_wr[k] = 1'b0; data_addr[k] = 32'h0000_0100;
    end
    wait_accept();
    idle(4);

    // Continuous data traffic against a waiting fetch: fetch must win after
    // exactly STARVE_MAX data grants.
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'hBFC0_0020;
      data_req[k] = 1'b1; data_wr[k] = 1'b0; data_addr[k] = 32'h0000_0100;
      n3[k] = 0; d3[k] = 1'b0;
    end
    for (int c = 0; c < 60 && !(d3[0] && d3[1]); c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        acc_i[k] = inst_addr_ok[k];
        acc_d[k] = data_addr_ok[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!d3[k] && acc_i[k]) begin
          d3[k] = 1'b1; inst_req[k] = 1'b0; data_req[k] = 1'b0;
        end else if (!d3[k] && acc_d[k]) begin
          n3[k]++;
          data_addr[k] = data_addr[k] + 32'd4;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput("starve_done", k, {159'd0, d3[k]}, 160'd1);
      checkOutput("starve_grants", k, 160'(n3[k]), 160'(smax_of(k)));
    end
    idle(5);

    // Back-to-back data reads at 0x0, 0x4, 0x8.
    for (int k = 0; k < 2; k++) begin
      data_req[k] = 1'b1; data_wr[k] = 1'b0; data_addr[k] = 32'h0;
      n6[k] = 0; first6[k] = 0; last6[k] = 0;
    end
    for (int c = 0; c < 30 && (data_req[0] || data_req[1]); c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        acc_d[k] = data_addr_ok[k];
        if (acc_d[k]) begin
          if (n6[k] == 0) first6[k] = cyc;
          last6[k] = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        if (acc_d[k]) begin
          n6[k]++;
          if (n6[k] < 3) data_addr[k] = data_addr[k] + 32'd4;
          else data_req[k] = 1'b0;
        end
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput("b2b_count", k, 160'(n6[k]), 160'd3);
      checkOutput("b2b_span", k, 160'(last6[k] - first6[k]), 160'(2 * lat_of(k)));
    end
    idle(5);

    // Cancel the cycle after a fetch issues, with a data request waiting.
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'hBFC0_0010;
    end
    step();
    for (int k = 0; k < 2; k++) begin
      cancel[k] = 1'b1;
      data_req[k] = 1'b1; data_wr[k] = 1'b0; data_addr[k] = 32'h0000_0104;
    end
    wait_accept();
    idle(5);

    // Reset while a fetch is outstanding, then a normal fetch afterwards.
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'hBFC0_0008;
    end
    step();
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'hBFC0_000C;
    end
    wait_accept();
    idle(5);

    applyStimulus(2000);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b0; data_req[k] = 1'b0; cancel[k] = 1'b0;
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
